cache_lru_fill_sched: RTL

Fill scheduler that shares one `cache_lru` instance between the cache-miss fill path and the normal tag-access pipeline. It buffers incoming line fills, issues them to the LRU's fill port, and captures the returned victim way. It then drives the tag-memory write for the new line. Access pipeline LRU reads are arbitrated against fills with a bounded-starvation rule. The block sits in each L1 cache between the L2 response interface, the tag stage and `cache_lru`.

---
 rtl/cache_lru_fill_sched.sv | 104 ++++++++++
 1 files changed

// File: rtl/cache_lru_fill_sched.sv
// cache_lru_fill_sched: buffers line fills, shares cache_lru between fills and accesses; optional CACHE_LRU_FILL_SCHED_STATS_EN counters
module cache_lru_fill_sched #(
  parameter int NUM_SETS        = 64,
  parameter int NUM_WAYS        = 4,
  parameter int TAG_WIDTH       = 20,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_FILL_BURST  = 4,
  parameter int SET_INDEX_WIDTH = $clog2(NUM_SETS),
  parameter int WAY_INDEX_WIDTH = $clog2(NUM_WAYS),
  parameter int CNT_WIDTH       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fill_req_valid,
  input  logic [SET_INDEX_WIDTH-1:0] fill_req_set,
  input  logic [TAG_WIDTH-1:0]       fill_req_tag,
  output logic                       fill_req_ready,
  input  logic                       acc_req,
  input  logic [SET_INDEX_WIDTH-1:0] acc_set,
  output logic                       acc_grant,
  output logic                       lru_fill_en,
  output logic [SET_INDEX_WIDTH-1:0] lru_fill_set,
  input  logic [WAY_INDEX_WIDTH-1:0] lru_fill_way,
  output logic                       lru_access_en,
  output logic [SET_INDEX_WIDTH-1:0] lru_access_set,
  output logic                       tag_wr_en,
  output logic [SET_INDEX_WIDTH-1:0] tag_wr_set,
  output logic [WAY_INDEX_WIDTH-1:0] tag_wr_way,
  output logic [TAG_WIDTH-1:0]       tag_wr_tag,
  output logic [CNT_WIDTH-1:0]       fills_pending
`ifdef CACHE_LRU_FILL_SCHED_STATS_EN
  ,
  output logic [31:0]                fill_count,
  output logic [31:0]                preempt_count
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = $clog2(MAX_FILL_BURST + 1);
  localparam logic [PW-1:0] P1 = PW'(1);
  localparam logic [SW-1:0] S1 = SW'(1);
  logic [SET_INDEX_WIDTH-1:0] set_mem [FIFO_DEPTH];
  logic [TAG_WIDTH-1:0]       tag_mem [FIFO_DEPTH];
  logic [PW-1:0]              rd_q, wr_q;
  logic [CNT_WIDTH-1:0]       cnt_q;
  logic [SW-1:0]              starve_q;
  logic                       v_q;
  logic [SET_INDEX_WIDTH-1:0] set_q;
  logic [TAG_WIDTH-1:0]       tag_q;
  logic                       full, empty, starved, push, pop, denied;
  assign full    = cnt_q == CNT_WIDTH'(FIFO_DEPTH);
  assign empty   = cnt_q == '0;
  assign starved = acc_req && starve_q == SW'(MAX_FILL_BURST);
  // Outputs toward cache_lru are held quiet during reset so discarded fills never touch LRU state
  assign pop     = !reset && !empty && !starved;
  assign push    = fill_req_valid && !full;
  assign acc_grant = !reset && !pop && acc_req;
  assign denied  = acc_req && !acc_grant;
  assign fill_req_ready = !full;
  assign lru_fill_en    = pop;
  assign lru_fill_set   = pop ? set_mem[rd_q] : '0;
  assign lru_access_en  = acc_grant;
  assign lru_access_set = acc_grant ? acc_set : '0;
  assign tag_wr_en      = v_q;
  assign tag_wr_set     = set_q;
  assign tag_wr_tag     = tag_q;
  assign tag_wr_way     = v_q ? lru_fill_way : '0;
  assign fills_pending  = cnt_q;
  always_ff @(posedge clk) begin
    if (push) begin
      set_mem[wr_q] <= fill_req_set;
      tag_mem[wr_q] <= fill_req_tag;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q     <= '0;
      wr_q     <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      v_q      <= 1'b0;
      set_q    <= '0;
      tag_q    <= '0;
    end else begin
      wr_q     <= push ? wr_q + P1 : wr_q;
      rd_q     <= pop ? rd_q + P1 : rd_q;
      cnt_q    <= cnt_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop);
      starve_q <= denied ? (starved ? starve_q : starve_q + S1) : '0;
      v_q      <= pop;
      set_q    <= lru_fill_set;
      tag_q    <= pop ? tag_mem[rd_q] : '0;
    end
  end
`ifdef CACHE_LRU_FILL_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_count    <= '0;
      preempt_count <= '0;
    end else begin
      fill_count    <= fill_count + 32'(pop);
      preempt_count <= preempt_count + 32'(denied);
    end
  end
`endif
endmodule
